// File: rtl/irq_priority_encoder_74148.sv
// 8-line interrupt priority encoder ('148 style) with per-line request latching.
// Optional preemption of the presented vector: IRQ_PRIORITY_ENCODER_PREEMPT_EN.
module irq_priority_encoder_74148 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         C,
    input  logic         nR,
    input  logic [N-1:0] i_n,
    input  logic         ei_n,
    input  logic         ack_n,
    output logic [W-1:0] a_n,
    output logic         gs_n,
    output logic         eo_n
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        HOLDOFF
    } state_t;

    state_t       state;
    state_t       state_d;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] s3;
    logic [N-1:0] fall;
    logic [N-1:0] pending;
    logic [N-1:0] pending_d;
    logic [N-1:0] clr;
    logic [W-1:0] vec;
    logic [W-1:0] vec_d;
    logic [W-1:0] top;
    logic         any;

    function automatic logic [W-1:0] highest(input logic [N-1:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (p[k]) begin
                r = W'(k);
            end
        end
        return r;
    endfunction

    always_comb begin
        fall    = ~s2 & s3;
        top     = highest(pending);
        any     = |pending;
        state_d = state;
        vec_d   = vec;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (!ei_n && any) begin
                    vec_d   = top;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (!ack_n) begin
                    clr     = {{(N-1){1'b0}}, 1'b1} << vec;
                    state_d = HOLDOFF;
                end else if (ei_n) begin
                    state_d = IDLE;
`ifdef IRQ_PRIORITY_ENCODER_PREEMPT_EN
                end else if (any && (top > vec)) begin
                    vec_d = top;
`endif
                end
            end
            HOLDOFF: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // a new edge on the bit being acknowledged keeps it pending
        pending_d = (pending & ~clr) | fall;
    end

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            s1      <= '1;
            s2      <= '1;
            s3      <= '1;
            pending <= '0;
            state   <= IDLE;
            vec     <= '0;
            a_n     <= '1;
            gs_n    <= 1'b1;
        end else begin
            s1      <= i_n;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_d;
            state   <= state_d;
            vec     <= vec_d;
            gs_n    <= (state_d != PRESENT);
            a_n     <= (state_d == PRESENT) ? ~vec_d : '1;
        end
    end

    assign eo_n = ~(~ei_n & ~any & (state == IDLE));

endmodule

// File: doc/irq_priority_encoder_74148.md
Name: irq_priority_encoder_74148

Overview:
- Sequential counterpart to the 3-to-8 decoder: an 8-line to 3-line interrupt priority encoder with per-line request latching.
- Modelled on SN74LS148 (K555IV1) plus an SN74LS279-style request latch.
- Synchronises active-low request lines, captures falling edges as pending requests, and presents the highest-priority pending index.
- Holds that index stable until acknowledged, then clears it.
- Sits between peripheral request lines and the CPU/vector logic; cascades via ei_n/eo_n like a '148.

Parameters:
- N, 8, number of request lines (index N-1 has highest priority).
- W, 3, vector width; must satisfy 2**W >= N.

Ports:
- C  in  1  clock, rising edge.
- nR  in  1  reset; one clock, reset is asynchronous and active-low.
- i_n  in  N  request lines, active-low, asynchronous to C.
- ei_n  in  1  enable input, active-low, synchronous.
- ack_n  in  1  acknowledge of the presented vector, active-low, sampled on C.
- a_n  out  W  encoded vector, active-low (inverted index as on a '148).
- gs_n  out  1  group select, active-low; vector valid.
- eo_n  out  1  enable output for cascading, active-low.

Behaviour:
- Reset (nR=0, async):
  - Sync stages and previous-value flops all set to 1.
  - pending=0; state=IDLE; vec=0.
  - Outputs: a_n=all 1s, gs_n=1.
  - eo_n=ei_n; this is its combinational definition with pending=0 and state IDLE.
- Synchroniser: two flops per line (s1, s2), plus a history flop s3.
  - Request edge: fall[k] = ~s2[k] & s3[k].
  - A level held low generates exactly one edge.
  - Re-arming requires i_n[k] to return high for at least 2 cycles.
- Pending: on edge, pending[k] <= 1.
  - A further edge while pending[k]=1 merges; no count, no error.
  - If an edge and an ack-clear hit the same bit in the same cycle, the set wins.
- FSM states: IDLE, PRESENT, HOLDOFF.
  - IDLE: gs_n=1, a_n=all 1s.
    - If ei_n=0 and pending!=0: vec <= index of highest set bit, go to PRESENT.
    - ack_n is ignored in IDLE.
  - PRESENT: gs_n=0, a_n=~vec. vec is frozen; a higher-priority arrival does not preempt unless the optional feature is enabled.
    - ack_n=0: pending[vec] <= 0, go to HOLDOFF.
    - ei_n=1 (without ack): abort to IDLE; pending retained; gs_n=1 next cycle.
    - If ack_n=0 and ei_n=1 in the same cycle, ack takes priority.
  - HOLDOFF: exactly 1 cycle with gs_n=1, a_n=all 1s, then IDLE. Guarantees a visible gs_n gap between vectors.
- eo_n = ~(~ei_n & (pending==0) & state==IDLE). Combinational; low means "enabled, nothing to report".
- Latency: i_n[k] low set up before edge 0 → pending set at edge 2 → gs_n low after edge 3.
- Ack to next vector: ack sampled at edge t → HOLDOFF after t → next vector valid after t+2 if pending remains.
- Outputs a_n and gs_n are registered; eo_n is the only combinational output.
- Reset mid-PRESENT: all state is discarded immediately; the outputs return to their reset values asynchronously.

Optional Feature:
- Macro: IRQ_PRIORITY_ENCODER_PREEMPT_EN.
- Defined: in PRESENT, with ack_n=1 and ei_n=0, if the highest pending index exceeds vec, vec updates to it on that edge. gs_n stays 0 and a_n changes with no gap; the lower request stays pending.
- Undefined: vec is frozen in PRESENT as described above.

Test Plan:
- Reset, then i_n=8'hFF, ei_n=0 → gs_n=1, a_n=3'b111, eo_n=0 indefinitely; after nR asserted, eo_n tracks ei_n.
- Drive i_n[5] low at edge 0 → gs_n=0, a_n=3'b010 after edge 3; ack_n=0 for one cycle → exactly one cycle gs_n=1, then IDLE with eo_n=0.
- Drive i_n[2] and i_n[6] low together → a_n=3'b001 (index 6). Ack → one holdoff cycle, then a_n=3'b101 (index 2). Ack → gs_n=1, eo_n=0.
- While presenting index 1, i_n[7] falls → without macro a_n stays 3'b110 until ack, then index 7; with macro a_n becomes 3'b000 and gs_n stays 0.
- During PRESENT raise ei_n → gs_n=1 next cycle, eo_n=1; lower ei_n → same index re-presented 1 cycle later.
- Pulse i_n[3] low again in the same cycle its ack clears pending[3] → pending[3] remains set and index 3 is re-presented after holdoff; assert nR mid-PRESENT → gs_n=1 and a_n=3'b111 immediately.
